// File: rtl/pio_rx_tlp_decoder.sv
// ---------------------------------------------------------------------------
// pio_rx_tlp_decoder
//
// Receive side of the PIO endpoint. Takes 64-bit AXI-Stream TLPs from the
// PCIe core and decodes single-DW memory reads and writes.
//   - A memory write produces a single-cycle wr_en with its address, data and
//     byte enables.
//   - A memory read latches the header fields and produces a single-cycle
//     req_compl/req_rd_en pulse for the completion TX engine.
// The decoder holds m_axis_rx_tready low until the completion has been sent
// (compl_done) or the write has been committed (wr_busy low). Every other TLP
// is drained and counted in the saturating drop_cnt.
//
// Optional feature macro: PIO_RX_MEM64_EN
//   When defined, 4DW MRd64/MWr64 TLPs are also decoded. Beat1 carries
//   {addr_lo, addr_hi}, and the upper address DW is discarded. MWr64 takes its
//   write data from beat2. When undefined, 4DW TLPs are dropped like any other
//   unsupported type.
//
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   m_axis_rx_*           AXIS TLP input (tkeep ignored, 1-DW payloads only)
//   req_compl/_wd         read accepted, completion with data required
//   compl_done            completion sent by the TX engine
//   req_tc/td/ep/attr     header TC, TD, EP and Attr of the last beat0
//   req_len/rid/tag/be    header Length, requester ID, tag and {last, first} BE
//   req_addr, req_rd_en   read byte address and single-cycle memory read strobe
//   wr_addr/data/be/en    write address, data, byte enables and strobe
//   wr_busy               target memory is still committing a write
//   drop_cnt              saturating count of discarded TLPs
//
// TCQ is kept for interface compatibility. Registered assignments carry no
// modelled delay.
// ---------------------------------------------------------------------------
module pio_rx_tlp_decoder #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int TCQ          = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
    input  logic                    m_axis_rx_tlast,
    input  logic                    m_axis_rx_tvalid,
    output logic                    m_axis_rx_tready,
    output logic                    req_compl,
    output logic                    req_compl_wd,
    input  logic                    compl_done,
    output logic [2:0]              req_tc,
    output logic                    req_td,
    output logic                    req_ep,
    output logic [1:0]              req_attr,
    output logic [9:0]              req_len,
    output logic [15:0]             req_rid,
    output logic [7:0]              req_tag,
    output logic [7:0]              req_be,
    output logic [31:0]             req_addr,
    output logic                    req_rd_en,
    output logic [31:0]             wr_addr,
    output logic [31:0]             wr_data,
    output logic [7:0]              wr_be,
    output logic                    wr_en,
    input  logic                    wr_busy,
    output logic [7:0]              drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_QW1,
        S_WR_QW1,
        S_WAIT_CPL,
        S_WAIT_WR,
`ifdef PIO_RX_MEM64_EN
        S_WR_QW2,
`endif
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic        r_tready;
    logic        r_req_compl;
    logic        r_req_compl_wd;
    logic        r_req_rd_en;
    logic [2:0]  r_req_tc;
    logic        r_req_td;
    logic        r_req_ep;
    logic [1:0]  r_req_attr;
    logic [9:0]  r_req_len;
    logic [15:0] r_req_rid;
    logic [7:0]  r_req_tag;
    logic [7:0]  r_req_be;
    logic [31:0] r_req_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [7:0]  r_wr_be;
    logic        r_wr_en;
    logic [7:0]  r_drop_cnt;
`ifdef PIO_RX_MEM64_EN
    logic        r_is64;
`endif

    logic        w_accept;
    logic [6:0]  w_fmt_type;
    logic        w_len_one;
    logic        w_is_rd;
    logic        w_is_wr;
    logic        w_unused;

    assign w_accept   = m_axis_rx_tvalid & r_tready;
    assign w_fmt_type = m_axis_rx_tdata[30:24];
    assign w_len_one  = (m_axis_rx_tdata[9:0] == 10'd1);

`ifdef PIO_RX_MEM64_EN
    assign w_is_rd = w_len_one & ((w_fmt_type == 7'b00_00000) | (w_fmt_type == 7'b01_00000));
    assign w_is_wr = w_len_one & ((w_fmt_type == 7'b10_00000) | (w_fmt_type == 7'b11_00000));
`else
    assign w_is_rd = w_len_one & (w_fmt_type == 7'b00_00000);
    assign w_is_wr = w_len_one & (w_fmt_type == 7'b10_00000);
`endif

    // Byte qualifiers carry no information for single-DW payloads.
    assign w_unused = (^m_axis_rx_tkeep) ^ (TCQ != 0);

    // Strobes default low every cycle so they can only ever last one cycle.
    // tready is registered. It is cleared when entering a wait state and set
    // again on the same edge that returns to IDLE, so the next beat0 can be
    // accepted in the very first IDLE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_tready       <= 1'b0;
            r_req_compl    <= 1'b0;
            r_req_compl_wd <= 1'b0;
            r_req_rd_en    <= 1'b0;
            r_req_tc       <= '0;
            r_req_td       <= 1'b0;
            r_req_ep       <= 1'b0;
            r_req_attr     <= '0;
            r_req_len      <= '0;
            r_req_rid      <= '0;
            r_req_tag      <= '0;
            r_req_be       <= '0;
            r_req_addr     <= '0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_wr_be        <= '0;
            r_wr_en        <= 1'b0;
            r_drop_cnt     <= '0;
`ifdef PIO_RX_MEM64_EN
            r_is64         <= 1'b0;
`endif
        end else begin
            r_req_compl <= 1'b0;
            r_req_rd_en <= 1'b0;
            r_wr_en     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        r_req_tc   <= m_axis_rx_tdata[22:20];
                        r_req_td   <= m_axis_rx_tdata[15];
                        r_req_ep   <= m_axis_rx_tdata[14];
                        r_req_attr <= m_axis_rx_tdata[13:12];
                        r_req_len  <= m_axis_rx_tdata[9:0];
                        r_req_rid  <= m_axis_rx_tdata[63:48];
                        r_req_tag  <= m_axis_rx_tdata[47:40];
                        r_req_be   <= m_axis_rx_tdata[39:32];
`ifdef PIO_RX_MEM64_EN
                        r_is64     <= w_fmt_type[5];
`endif
                        // A read/write ending on beat0 is truncated and dropped.
                        if (w_is_rd && !m_axis_rx_tlast) begin
                            r_state <= S_RD_QW1;
                        end else if (w_is_wr && !m_axis_rx_tlast) begin
                            r_state <= S_WR_QW1;
                        end else begin
                            if (r_drop_cnt != 8'hFF) begin
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            end
                            if (!m_axis_rx_tlast) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_RD_QW1: begin
                    if (w_accept) begin
`ifdef PIO_RX_MEM64_EN
                        r_req_addr <= r_is64 ? {m_axis_rx_tdata[63:34], 2'b00}
                                             : {m_axis_rx_tdata[31:2], 2'b00};
`else
                        r_req_addr <= {m_axis_rx_tdata[31:2], 2'b00};
`endif
                        r_req_compl    <= 1'b1;
                        r_req_rd_en    <= 1'b1;
                        r_req_compl_wd <= 1'b1;
                        r_tready       <= 1'b0;
                        r_state        <= S_WAIT_CPL;
                    end
                end
                S_WR_QW1: begin
                    if (w_accept) begin
                        r_wr_be <= r_req_be;
`ifdef PIO_RX_MEM64_EN
                        if (r_is64) begin
                            r_wr_addr <= {m_axis_rx_tdata[63:34], 2'b00};
                            r_state   <= S_WR_QW2;
                        end else begin
                            r_wr_addr <= {m_axis_rx_tdata[31:2], 2'b00};
                            r_wr_data <= m_axis_rx_tdata[63:32];
                            r_wr_en   <= 1'b1;
                            r_tready  <= 1'b0;
                            r_state   <= S_WAIT_WR;
                        end
`else
                        r_wr_addr <= {m_axis_rx_tdata[31:2], 2'b00};
                        r_wr_data <= m_axis_rx_tdata[63:32];
                        r_wr_en   <= 1'b1;
                        r_tready  <= 1'b0;
                        r_state   <= S_WAIT_WR;
`endif
                    end
                end
`ifdef PIO_RX_MEM64_EN
                S_WR_QW2: begin
                    if (w_accept) begin
                        r_wr_data <= m_axis_rx_tdata[31:0];
                        r_wr_en   <= 1'b1;
                        r_tready  <= 1'b0;
                        r_state   <= S_WAIT_WR;
                    end
                end
`endif
                S_WAIT_CPL: begin
                    if (compl_done) begin
                        r_tready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_WAIT_WR: begin
                    // The memory cannot raise wr_busy before it has seen
                    // wr_en, so busy is only trusted after the strobe cycle.
                    if (!r_wr_en && !wr_busy) begin
                        r_tready <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && m_axis_rx_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tready <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign m_axis_rx_tready = r_tready;
    assign req_compl        = r_req_compl;
    assign req_compl_wd     = r_req_compl_wd;
    assign req_rd_en        = r_req_rd_en;
    assign req_tc           = r_req_tc;
    assign req_td           = r_req_td;
    assign req_ep           = r_req_ep;
    assign req_attr         = r_req_attr;
    assign req_len          = r_req_len;
    assign req_rid          = r_req_rid;
    assign req_tag          = r_req_tag;
    assign req_be           = r_req_be;
    assign req_addr         = r_req_addr;
    assign wr_addr          = r_wr_addr;
    assign wr_data          = r_wr_data;
    assign wr_be            = r_wr_be;
    assign wr_en            = r_wr_en;
    assign drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_pio_rx_tlp_decoder.sv
// ---------------------------------------------------------------------------
// tb_pio_rx_tlp_decoder
//
// Scoreboard bench for pio_rx_tlp_decoder. Each scenario pushes the strobe
// it expects (read completion request or memory write) into expQ while
// driving the TLP. A negedge monitor pops one entry for every strobe cycle
// and compares the outputs against it. Scenario tasks check tready
// throttling, drop_cnt and that every expected strobe was consumed.
// Build with +define+PIO_RX_MEM64_EN to exercise the 64-bit address path.
// ---------------------------------------------------------------------------
module tb_pio_rx_tlp_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = 8'hFF;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        req_compl;
    logic        req_compl_wd;
    logic        compl_done = 1'b0;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [7:0]  req_be;
    logic [31:0] req_addr;
    logic        req_rd_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  wr_be;
    logic        wr_en;
    logic        wr_busy = 1'b0;
    logic [7:0]  drop_cnt;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  be;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [2:0]  tc;
        logic [1:0]  attr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    localparam logic [6:0] FT_MRD32 = 7'b00_00000;
    localparam logic [6:0] FT_MWR32 = 7'b10_00000;
    localparam logic [6:0] FT_MWR64 = 7'b11_00000;
    localparam logic [6:0] FT_MSG   = 7'b01_10000;

    pio_rx_tlp_decoder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_axis_rx_tdata  (tdata),
        .m_axis_rx_tkeep  (tkeep),
        .m_axis_rx_tlast  (tlast),
        .m_axis_rx_tvalid (tvalid),
        .m_axis_rx_tready (tready),
        .req_compl        (req_compl),
        .req_compl_wd     (req_compl_wd),
        .compl_done       (compl_done),
        .req_tc           (req_tc),
        .req_td           (req_td),
        .req_ep           (req_ep),
        .req_attr         (req_attr),
        .req_len          (req_len),
        .req_rid          (req_rid),
        .req_tag          (req_tag),
        .req_be           (req_be),
        .req_addr         (req_addr),
        .req_rd_en        (req_rd_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_be            (wr_be),
        .wr_en            (wr_en),
        .wr_busy          (wr_busy),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    // Beat0 layout: {rid, tag, be, R, fmt_type, R, tc, R, td, ep, attr, R, len}
    function automatic logic [63:0] mkHdr(input logic [6:0] ft, input logic [9:0] len,
                                          input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [7:0] be, input logic [2:0] tc,
                                          input logic [1:0] attr);
        return {rid, tag, be, 1'b0, ft, 1'b0, tc, 4'b0000, 1'b0, 1'b0, attr, 2'b00, len};
    endfunction

    task automatic pushRead(input logic [31:0] addr, input logic [7:0] be, input logic [7:0] tag,
                            input logic [15:0] rid, input logic [2:0] tc, input logic [1:0] attr);
        exp_t e;
        e.isWrite = 1'b0; e.addr = addr; e.data = '0; e.be = be;
        e.tag = tag; e.rid = rid; e.tc = tc; e.attr = attr;
        expQ.push_back(e);
    endtask

    task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] be);
        exp_t e;
        e.isWrite = 1'b1; e.addr = addr; e.data = data; e.be = be;
        e.tag = '0; e.rid = '0; e.tc = '0; e.attr = '0;
        expQ.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic sendBeat(input logic [63:0] d, input logic last, output int waited);
        waited = 0;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        while (tready !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 40) begin
            checks++; failures++;
            $display("[TB] FAIL handshake: tready stayed %b for %0d cycles, required 1", tready, waited);
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulseComplDone();
        compl_done = 1'b1;
        @(posedge clk); #1;
        compl_done = 1'b0;
    endtask

    // Scoreboard monitor: one expected entry per strobe cycle.
    exp_t monE;
    always @(negedge clk) begin
        if (req_compl || req_rd_en || wr_en) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL strobe_unexpected: req_compl=%b req_rd_en=%b wr_en=%b, required no strobe",
                         req_compl, req_rd_en, wr_en);
            end else begin
                monE = expQ.pop_front();
                if (!monE.isWrite) begin
                    if ({req_compl, req_rd_en, wr_en, req_compl_wd} !== 4'b1101 || req_addr !== monE.addr ||
                        req_tag !== monE.tag || req_be !== monE.be || req_rid !== monE.rid ||
                        req_tc !== monE.tc || req_attr !== monE.attr || req_len !== 10'd1 ||
                        req_td !== 1'b0 || req_ep !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL read_req: cpl/rd/wr/wd=%b%b%b%b addr=%h tag=%h be=%h rid=%h tc=%0d attr=%0d len=%0d, required 1101 addr=%h tag=%h be=%h rid=%h tc=%0d attr=%0d len=1",
                                 req_compl, req_rd_en, wr_en, req_compl_wd, req_addr, req_tag, req_be, req_rid,
                                 req_tc, req_attr, req_len, monE.addr, monE.tag, monE.be, monE.rid, monE.tc, monE.attr);
                    end
                end else begin
                    if ({req_compl, req_rd_en, wr_en} !== 3'b001 || wr_addr !== monE.addr ||
                        wr_data !== monE.data || wr_be !== monE.be) begin
                        failures++;
                        $display("[TB] FAIL write: cpl/rd/wr=%b%b%b addr=%h data=%h be=%h, required 001 addr=%h data=%h be=%h",
                                 req_compl, req_rd_en, wr_en, wr_addr, wr_data, wr_be, monE.addr, monE.data, monE.be);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        idleCycles(3);
        checks++;
        if ({tready, req_compl, req_rd_en, wr_en, req_compl_wd} !== 5'b0 || drop_cnt !== 8'h00 ||
            req_addr !== 32'h0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: tready=%b strobes=%b%b%b drop_cnt=%h, required all 0",
                     tready, req_compl, req_rd_en, wr_en, drop_cnt);
        end
        rst_n = 1'b1;
        idleCycles(1);
        checks++;
        if (tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_tready: tready=%b, required 1 after first cycle", tready);
        end
    endtask

    task automatic test_mrd32();
        int w;
        pushRead(32'h0000_0104, 8'h0F, 8'h2A, 16'h0100, 3'd2, 2'b01);
        sendBeat(mkHdr(FT_MRD32, 10'd1, 16'h0100, 8'h2A, 8'h0F, 3'd2, 2'b01), 1'b0, w);
        sendBeat({32'h0, 32'h0000_0104}, 1'b1, w);
        checks++;
        if (tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mrd32_throttle: tready=%b in strobe cycle, required 0", tready);
        end
        idleCycles(3);
        checks++;
        if (tready !== 1'b0 || req_addr !== 32'h104 || req_tag !== 8'h2A) begin
            failures++;
            $display("[TB] FAIL mrd32_hold: tready=%b addr=%h tag=%h, required 0 104 2a", tready, req_addr, req_tag);
        end
        pulseComplDone();
        checks++;
        if (tready !== 1'b1 || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL mrd32_done: tready=%b pending=%0d, required 1 0", tready, expQ.size());
        end
    endtask

    task automatic test_mwr32();
        int w;
        pushWrite(32'h0000_0010, 32'hDEADBEEF, 8'h0F);
        sendBeat(mkHdr(FT_MWR32, 10'd1, 16'h0200, 8'h05, 8'h0F, 3'd0, 2'b00), 1'b0, w);
        sendBeat({32'hDEADBEEF, 32'h0000_0010}, 1'b1, w);
        // Cycle with wr_en, then wr_busy high for 3 cycles, then one low cycle.
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mwr32_throttle: cycle %0d tready=%b, required 0", i, tready);
            end
            @(posedge clk); #1;
            wr_busy = (i < 3);
        end
        checks++;
        if (tready !== 1'b1 || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL mwr32_release: tready=%b pending=%0d, required 1 0", tready, expQ.size());
        end
    endtask

    task automatic test_drops();
        int w;
        int waitSum = 0;
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL drops_start: drop_cnt=%0d, required 0", drop_cnt);
        end
        sendBeat(mkHdr(FT_MRD32, 10'd2, 16'h0300, 8'h11, 8'hFF, 3'd0, 2'b00), 1'b0, w);
        waitSum += w;
        checks++;
        if (drop_cnt !== 8'd1) begin
            failures++;
            $display("[TB] FAIL drops_first: drop_cnt=%0d, required 1", drop_cnt);
        end
        sendBeat({32'h0, 32'h0000_0200}, 1'b1, w);
        waitSum += w;
        sendBeat(mkHdr(FT_MSG, 10'd0, 16'h0300, 8'h12, 8'h00, 3'd0, 2'b00), 1'b0, w);
        waitSum += w;
        sendBeat(64'h1111_2222_3333_4444, 1'b0, w);
        waitSum += w;
        sendBeat(64'h5555_6666_7777_8888, 1'b1, w);
        waitSum += w;
        checks++;
        if (drop_cnt !== 8'd2 || waitSum != 0 || tready !== 1'b1 || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drops_end: drop_cnt=%0d stalls=%0d tready=%b, required 2 0 1", drop_cnt, waitSum, tready);
        end
    endtask

    task automatic test_tvalid_gaps();
        int w;
        pushRead(32'h0000_0104, 8'h0F, 8'h2A, 16'h0100, 3'd0, 2'b00);
        idleCycles(2);
        sendBeat(mkHdr(FT_MRD32, 10'd1, 16'h0100, 8'h2A, 8'h0F, 3'd0, 2'b00), 1'b0, w);
        idleCycles(2);
        checks++;
        if (tready !== 1'b1 || expQ.size() != 1) begin
            failures++;
            $display("[TB] FAIL gaps_hold: tready=%b pending=%0d, required 1 1", tready, expQ.size());
        end
        sendBeat({32'h0, 32'h0000_0104}, 1'b1, w);
        idleCycles(2);
        pulseComplDone();
        checks++;
        if (tready !== 1'b1 || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL gaps_done: tready=%b pending=%0d, required 1 0", tready, expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        int w;
        sendBeat(mkHdr(FT_MWR32, 10'd1, 16'h0400, 8'h21, 8'h0F, 3'd0, 2'b00), 1'b0, w);
        rst_n = 1'b0;
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);
        checks++;
        if (tready !== 1'b1 || drop_cnt !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid: tready=%b drop_cnt=%0d, required 1 0", tready, drop_cnt);
        end
        pushRead(32'h0000_0040, 8'h03, 8'h33, 16'h0400, 3'd1, 2'b10);
        sendBeat(mkHdr(FT_MRD32, 10'd1, 16'h0400, 8'h33, 8'h03, 3'd1, 2'b10), 1'b0, w);
        sendBeat({32'h0, 32'h0000_0043}, 1'b1, w);
        pulseComplDone();
        checks++;
        if (drop_cnt !== 8'd0 || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_read: drop_cnt=%0d pending=%0d, required 0 0", drop_cnt, expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        int w;
        pushWrite(32'h0000_0080, 32'hCAFE_F00D, 8'hF3);
        sendBeat(mkHdr(FT_MWR32, 10'd1, 16'h0500, 8'h40, 8'hF3, 3'd0, 2'b00), 1'b0, w);
        sendBeat({32'hCAFE_F00D, 32'h0000_0080}, 1'b1, w);
        pushRead(32'h0000_0088, 8'h0F, 8'h41, 16'h0500, 3'd0, 2'b00);
        sendBeat(mkHdr(FT_MRD32, 10'd1, 16'h0500, 8'h41, 8'h0F, 3'd0, 2'b00), 1'b0, w);
        checks++;
        if (w != 2) begin
            failures++;
            $display("[TB] FAIL b2b_latency: beat0 stalled %0d cycles, required 2", w);
        end
        sendBeat({32'h0, 32'h0000_0088}, 1'b1, w);
        pulseComplDone();
        checks++;
        if (expQ.size() != 0 || tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_done: pending=%0d tready=%b, required 0 1", expQ.size(), tready);
        end
    endtask

    task automatic test_truncated();
        int w;
        sendBeat(mkHdr(FT_MRD32, 10'd1, 16'h0600, 8'h50, 8'h0F, 3'd0, 2'b00), 1'b1, w);
        checks++;
        if (drop_cnt !== 8'd1 || tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL truncated: drop_cnt=%0d tready=%b, required 1 1", drop_cnt, tready);
        end
        pulseComplDone();
        pushWrite(32'h0000_00C0, 32'h0BAD_CAFE, 8'h0F);
        sendBeat(mkHdr(FT_MWR32, 10'd1, 16'h0600, 8'h51, 8'h0F, 3'd0, 2'b00), 1'b0, w);
        checks++;
        if (w != 0) begin
            failures++;
            $display("[TB] FAIL truncated_idle: stalled %0d cycles, required 0", w);
        end
        sendBeat({32'h0BAD_CAFE, 32'h0000_00C0}, 1'b1, w);
        idleCycles(2);
        checks++;
        if (expQ.size() != 0 || tready !== 1'b1 || drop_cnt !== 8'd1) begin
            failures++;
            $display("[TB] FAIL truncated_write: pending=%0d tready=%b drop_cnt=%0d, required 0 1 1",
                     expQ.size(), tready, drop_cnt);
        end
    endtask

    task automatic test_mem64();
        int w;
        logic [7:0] base;
        logic [7:0] wantDrops;
        base = drop_cnt;
`ifdef PIO_RX_MEM64_EN
        pushWrite(32'h0000_0020, 32'h1234_5678, 8'h0F);
        wantDrops = base;
`else
        wantDrops = base + 8'd1;
`endif
        sendBeat(mkHdr(FT_MWR64, 10'd1, 16'h0700, 8'h60, 8'h0F, 3'd0, 2'b00), 1'b0, w);
        sendBeat({32'h0000_0020, 32'h0000_0001}, 1'b0, w);
        sendBeat({32'h0, 32'h1234_5678}, 1'b1, w);
        idleCycles(3);
        checks++;
        if (expQ.size() != 0 || drop_cnt !== wantDrops || tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mem64: pending=%0d drop_cnt=%0d tready=%b, required 0 %0d 1",
                     expQ.size(), drop_cnt, tready, wantDrops);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_mrd32();
        test_mwr32();
        test_drops();
        test_tvalid_gaps();
        test_reset_mid();
        test_back_to_back();
        test_truncated();
        test_mem64();
        idleCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
